// File: rtl/div_seq_ctrl.sv
// Sequences one DIV/DIVU from EX onto the shared iterative divider, stalling EX until the result is held,
// then issues one HI/LO write on the EX->MEM transfer. Handles flush, divide-by-zero bypass and a lost-completion watchdog.
module div_seq_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        pipe_adv,
  output logic        stall_req,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic        hilo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wdog_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             div_zero;
  logic             done_hit;
  logic             wdog_hit;

  assign accept   = (state == IDLE) & ex_valid & (op_div | op_divu) & ~flush;
  assign div_zero = (src_b == 32'd0);
  // Flush outranks completion, completion outranks the watchdog.
  assign done_hit = (state == BUSY) & ~flush & div_done;
  assign wdog_hit = (state == BUSY) & ~flush & ~div_done & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = div_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (div_done || (cnt == CNT_LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (flush || pipe_adv) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_req  = accept | (state == BUSY);
    div_cancel = (state == BUSY) & (flush | (~div_done & (cnt == CNT_LAST)));
    hilo_we    = (state == DONE) & pipe_adv & ~flush;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_start    <= 1'b0;
      cnt          <= '0;
      div_signed   <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      wdog_err     <= 1'b0;
    end else begin
      div_start <= accept & ~div_zero;
      if (accept) begin
        cnt          <= '0;
        div_signed   <= op_div;
        div_dividend <= src_a;
        div_divisor  <= src_b;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept && div_zero) begin
        hi <= src_a;
        lo <= 32'hFFFF_FFFF;
      end else if (done_hit) begin
        hi <= div_result[63:32];
        lo <= div_result[31:0];
      end else if (wdog_hit) begin
        hi <= 32'd0;
        lo <= 32'd0;
      end
      wdog_err <= wdog_err | wdog_hit;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized scoreboard bench for div_seq_ctrl with a behavioural divider and arithmetic reference.
module tb_div_seq_ctrl;
  localparam int MAX = 40;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, op_div, op_divu, flush, pipe_adv;
  logic [31:0] src_a, src_b;
  logic        stall_req, div_start, div_cancel, div_signed;
  logic [31:0] div_dividend, div_divisor;
  logic        div_done;
  logic [63:0] div_result;
  logic        hilo_we;
  logic [31:0] hi, lo;
  logic        wdog_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic        exp_wdog = 1'b0;
  logic        exp_sgn;
  logic [31:0] exp_a, exp_b;
  int          dv_lat = 0;
  logic        dv_busy = 1'b0;
  logic [63:0] m_res;

  div_seq_ctrl #(.MAX_CYCLES(MAX), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .op_div(op_div), .op_divu(op_divu),
    .src_a(src_a), .src_b(src_b), .flush(flush), .pipe_adv(pipe_adv), .stall_req(stall_req),
    .div_start(div_start), .div_cancel(div_cancel), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
    .div_result(div_result), .hilo_we(hilo_we), .hi(hi), .lo(lo), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {remainder, quotient}; a zero divisor yields the bypass value.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = a; sb = b;
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Behavioural divider: answers dv_lat cycles after the launch, or never if that is past the watchdog.
  initial begin
    div_done = 1'b0;
    div_result = 64'd0;
    forever begin
      @(negedge clk);
      if (resetn && div_start) begin
        chk("div_operands", {63'd0, div_signed, div_dividend, div_divisor}, {63'd0, exp_sgn, exp_a, exp_b});
        if (dv_lat + 1 <= MAX) begin
          m_res = ref_div(div_signed, div_dividend, div_divisor);
          dv_busy = 1'b1;
          repeat (dv_lat) @(posedge clk);
          #1 div_done = 1'b1; div_result = m_res;
          @(posedge clk);
          #1 div_done = 1'b0; dv_busy = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every HI/LO write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn && hilo_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hilo_we", {95'd0, 1'b1}, 96'd0);
      end else begin
        chk("hilo_write", {32'd0, hi, lo}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // kind: 0 DIVU, 1 DIV, 2 both opcode bits. f: -1 no flush, -2 random flush, else flush cycle.
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int f_in, input int d);
    logic sgn, zero, wd, flushed;
    int e, endk, f;
    logic [63:0] res;
    for (int i = 0; i < 100 && dv_busy; i++) @(posedge clk);
    if (dv_busy) chk("divider_idle_timeout", 96'd1, 96'd0);
    sgn  = (kind != 0);
    zero = (b == 32'd0);
    wd   = !zero && (lat + 1 > MAX);
    e    = zero ? 0 : (wd ? MAX : lat + 1);
    endk = e + 1 + d;
    f    = (f_in == -2) ? int'($urandom_range(1, endk)) : f_in;
    flushed = (f >= 1) && (f <= endk);
    if (flushed) endk = f;
    res = wd ? 64'd0 : ref_div(sgn, a, b);
    if (!flushed) exp_q.push_back(res);
    if (wd && !(flushed && f <= e)) exp_wdog = 1'b1;
    exp_sgn = sgn; exp_a = a; exp_b = b; dv_lat = lat;
    for (int k = 0; k <= endk; k++) begin
      @(posedge clk);
      #1;
      ex_valid = (k == 0);
      op_div   = (k == 0) && (kind != 0);
      op_divu  = (k == 0) && (kind != 1);
      src_a    = a;
      src_b    = b;
      flush    = (k == f);
      pipe_adv = (k == e + 1 + d);
      @(negedge clk);
      chk("stall_req", {95'd0, stall_req}, {95'd0, k <= e});
      chk("div_start", {95'd0, div_start}, {95'd0, !zero && k == 1});
      chk("div_cancel", {95'd0, div_cancel},
          {95'd0, !zero && k >= 1 && k <= e && (k == f || (wd && k == MAX))});
      if (k >= e + 1) chk("done_hold_hilo", {32'd0, hi, lo}, {32'd0, res});
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0; op_div = 1'b0; op_divu = 1'b0; flush = 1'b0; pipe_adv = 1'b0;
    @(negedge clk);
    chk("wdog_err", {95'd0, wdog_err}, {95'd0, exp_wdog});
  endtask

  initial begin
    logic [31:0] a, b;
    int kind, lat;
    resetn = 1'b0;
    ex_valid = 1'b0; op_div = 1'b0; op_divu = 1'b0; flush = 1'b0; pipe_adv = 1'b0;
    src_a = 32'd0; src_b = 32'd0;
    #12;
    chk("reset_outputs", {58'd0, stall_req, div_start, div_cancel, hilo_we, wdog_err, div_signed, hi, lo},
        96'd0);
    chk("reset_operands", {32'd0, div_dividend, div_divisor}, 96'd0);
    resetn = 1'b1;

    run_op(0, 32'd100, 32'd7, 32, -1, 0);
    run_op(1, -32'sd7, 32'd2, 32, -1, 3);
    run_op(0, 32'h1234, 32'd0, 0, -1, 0);
    run_op(0, 32'd5000, 32'd3, 32, 10, 0);
    run_op(1, 32'd77, 32'd5, 20, 21, 0);
    run_op(1, -32'sd100, 32'd9, 5, -1, 1);
    run_op(2, 32'd81, -32'sd4, 12, -1, 0);
    run_op(1, 32'd123, 32'd11, 60, -1, 1);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 50));
      if (kind != 0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat = ($urandom_range(0, 15) == 0) ? 50 : int'($urandom_range(1, 38));
      run_op(kind, a, b, lat, ($urandom_range(0, 4) == 0) ? -2 : -1, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a divide clears everything at once.
    exp_sgn = 1'b0; exp_a = 32'd999; exp_b = 32'd5; dv_lat = 50;
    @(posedge clk);
    #1 ex_valid = 1'b1; op_divu = 1'b1; src_a = 32'd999; src_b = 32'd5;
    @(posedge clk);
    #1 ex_valid = 1'b0; op_divu = 1'b0;
    repeat (9) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("midbusy_reset_outputs",
        {58'd0, stall_req, div_start, div_cancel, hilo_we, wdog_err, div_signed, hi, lo}, 96'd0);
    chk("midbusy_reset_operands", {32'd0, div_dividend, div_divisor}, 96'd0);
    exp_wdog = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {94'd0, stall_req, wdog_err}, 96'd0);
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
